// File: rtl/mips_defs.sv
// mips_defs: shared load-select encodings, MEM-stage FSM states and the MEM/WB record
package mips_defs;
    localparam logic [2:0] LS_LW  = 3'd0;
    localparam logic [2:0] LS_LB  = 3'd1;
    localparam logic [2:0] LS_LBU = 3'd2;
    localparam logic [2:0] LS_LH  = 3'd3;
    localparam logic [2:0] LS_LHU = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic        nop;
        logic [31:0] pc;
        logic        reg_w;
        logic [3:0]  reg_byte_w_en;
        logic [4:0]  rd_addr;
        logic [31:0] data;
        logic        bus_err;
    } memwb_t;

    localparam memwb_t MEMWB_RST = '{nop: 1'b1, default: '0};
endpackage

// File: rtl/load_extend.sv
// load_extend: picks the addressed byte/half of the read word and sign/zero-extends it
module load_extend
    import mips_defs::*;
(
    input  logic [31:0] rbuf,
    input  logic [1:0]  off,
    input  logic [2:0]  load_sel,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rbuf[{off, 3'b000} +: 8];
        h = off[1] ? rbuf[31:16] : rbuf[15:0];
        data = load_sel == LS_LB  ? {{24{b[7]}}, b} :
               load_sel == LS_LBU ? {24'h0, b} :
               load_sel == LS_LH  ? {{16{h[15]}}, h} :
               load_sel == LS_LHU ? {16'h0, h} : rbuf;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage bus handshake with timeout, load extension and MEM/WB register
module mem_access_unit
    import mips_defs::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cu_stall,
    input  logic        cu_flush,
    input  logic        mem_nop,
    input  logic [31:0] exmem_pc,
    input  logic        exmem_mem_r,
    input  logic        exmem_mem_w,
    input  logic        exmem_reg_w,
    input  logic [3:0]  reg_byte_w_en_out,
    input  logic [4:0]  exmem_rd_addr,
    input  logic [3:0]  mem_byte_w_en_out,
    input  logic [31:0] exmem_alu_res,
    input  logic [31:0] exmem_aligned_rt_data,
    input  logic [2:0]  exmem_load_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        memwb_nop,
    output logic [31:0] memwb_pc,
    output logic        memwb_reg_w,
    output logic [3:0]  memwb_reg_byte_w_en,
    output logic [4:0]  memwb_rd_addr,
    output logic [31:0] memwb_data,
    output logic        memwb_bus_err
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               err_q, err_d;
    logic [31:0]        rbuf_q, rbuf_d;
    memwb_t             memwb_q, memwb_d;
    logic               pending;
    logic [31:0]        ext;

    load_extend u_ext (
        .rbuf     (rbuf_q),
        .off      (exmem_alu_res[1:0]),
        .load_sel (exmem_load_sel),
        .data     (ext)
    );

    assign pending    = !mem_nop && (exmem_mem_r || (exmem_mem_w && |mem_byte_w_en_out));
    assign mem_stall  = pending && state_q != S_DONE;
    assign dmem_req   = req_q;
    assign dmem_we    = exmem_mem_w;
    assign dmem_addr  = {exmem_alu_res[31:2], 2'b00};
    assign dmem_be    = exmem_mem_r ? 4'hF : mem_byte_w_en_out;
    assign dmem_wdata = exmem_aligned_rt_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        err_d   = err_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            S_IDLE: if (pending) begin
                state_d = S_BUSY;
                req_d   = 1'b1;
                cnt_d   = '0;
            end
            S_BUSY: if (dmem_ack) begin
                state_d = S_DONE;
                req_d   = 1'b0;
                err_d   = 1'b0;
                rbuf_d  = dmem_rdata;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                state_d = S_DONE;
                req_d   = 1'b0;
                err_d   = 1'b1;
                rbuf_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_DONE: state_d = cu_stall ? S_DONE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        memwb_d = cu_stall ? memwb_q :
                  cu_flush ? MEMWB_RST :
                  memwb_t'{nop:           mem_nop,
                           pc:            exmem_pc,
                           reg_w:         exmem_reg_w,
                           reg_byte_w_en: reg_byte_w_en_out,
                           rd_addr:       exmem_rd_addr,
                           data:          exmem_mem_r ? ext : exmem_alu_res,
                           bus_err:       pending && err_q};
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            rbuf_q  <= '0;
            memwb_q <= MEMWB_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
            rbuf_q  <= rbuf_d;
            memwb_q <= memwb_d;
        end
    end

    assign memwb_nop           = memwb_q.nop;
    assign memwb_pc            = memwb_q.pc;
    assign memwb_reg_w         = memwb_q.reg_w;
    assign memwb_reg_byte_w_en = memwb_q.reg_byte_w_en;
    assign memwb_rd_addr       = memwb_q.rd_addr;
    assign memwb_data          = memwb_q.data;
    assign memwb_bus_err       = memwb_q.bus_err;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs. Drives the data-memory bus through a req/ack handshake and stalls the pipeline while an access is outstanding.
- Extracts and extends load data, then registers the MEM/WB pipeline outputs.
- Sits between exmem_reg and the MEM/WB consumers: writeback mux and forwarding.

Parameters:
TIMEOUT, 64, cycles in BUSY without dmem_ack before the access is aborted with a bus error
CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  pipeline clock; all state updates on negedge, as for the other pipeline registers
reset  in  1  synchronous, active-high reset
cu_stall  in  1  global stall from the control unit; includes mem_stall
cu_flush  in  1  flush request from the control unit
mem_nop  in  1  EX/MEM slot is a bubble
exmem_pc  in  32  PC of the instruction in MEM
exmem_mem_r  in  1  load
exmem_mem_w  in  1  store
exmem_reg_w  in  1  register write enable
reg_byte_w_en_out  in  4  register byte write enables
exmem_rd_addr  in  5  destination register
mem_byte_w_en_out  in  4  store byte lanes
exmem_alu_res  in  32  effective address, or ALU result
exmem_aligned_rt_data  in  32  lane-aligned store data
exmem_load_sel  in  3  load type
dmem_req  out  1  bus request (registered)
dmem_we  out  1  write strobe; valid while dmem_req is high
dmem_addr  out  32  word address: exmem_alu_res[31:2], 2'b00
dmem_be  out  4  byte enables: mem_byte_w_en_out for stores, 4'b1111 for loads
dmem_wdata  out  32  exmem_aligned_rt_data
dmem_ack  in  1  bus completion, one-cycle pulse
dmem_rdata  in  32  read data; valid when dmem_ack is high
mem_stall  out  1  stall request to the control unit (combinational)
memwb_nop  out  1  MEM/WB slot is a bubble
memwb_pc  out  32  PC
memwb_reg_w  out  1  register write enable
memwb_reg_byte_w_en  out  4  register byte write enables
memwb_rd_addr  out  5  destination register
memwb_data  out  32  writeback data
memwb_bus_err  out  1  the access timed out

Behaviour:
- Access definition: pending = !mem_nop && (exmem_mem_r || (exmem_mem_w && |mem_byte_w_en_out)).
- FSM states and transitions (all evaluated at negedge):
  - IDLE: if pending, go to BUSY with dmem_req<=1 and cnt<=0.
  - BUSY: if dmem_ack, capture dmem_rdata into rbuf, dmem_req<=0, err<=0, go to DONE. Else if cnt==TIMEOUT-1, dmem_req<=0, rbuf<=0, err<=1, go to DONE. Otherwise cnt<=cnt+1.
  - DONE: if !cu_stall, go to IDLE (the instruction advances this edge).
- Stall: mem_stall = pending && (state!=DONE).
- Minimum latency: 2 stall edges before DONE (request edge, then ack edge).
- Back-to-back accesses: leaving DONE lands in IDLE, and the next access requests on the following edge. The unit never skips IDLE.
- Bus outputs dmem_we, dmem_addr, dmem_be and dmem_wdata are combinational from the EX/MEM inputs. They are held stable because EX/MEM is stalled throughout BUSY.
- Load extraction uses off = exmem_alu_res[1:0] and the source word rbuf:
  - 0 = LW: whole word.
  - 1 = LB: byte[off], sign-extended.
  - 2 = LBU: byte[off], zero-extended.
  - 3 = LH: half[off[1]], sign-extended.
  - 4 = LHU: half[off[1]], zero-extended.
  - 5..7: whole word (LWL/LWR merging is done downstream using reg_byte_w_en).
- Writeback data: memwb_data = exmem_mem_r ? extracted : exmem_alu_res.
- MEM/WB register, negedge:
  - If reset or (!cu_stall && cu_flush): clear all memwb_* outputs to 0, with memwb_nop<=1.
  - Else if !cu_stall: load from the inputs above, with memwb_bus_err<=err when the slot was an access, else 0.
  - If cu_stall: hold.
- Flush during BUSY: ignored, because mem_stall forces cu_stall. The bus transaction always completes or times out; there is no abort.
- Ack arriving in IDLE or DONE is ignored.
- Reset (including mid-access): state<=IDLE, dmem_req<=0, cnt<=0, err<=0, rbuf<=0, memwb_nop<=1, all other outputs 0. mem_stall follows from the inputs.

Decomposition:
- Shared package (mips_defs): load_sel encodings LS_LW..LS_LHU, and FSM state encodings S_IDLE, S_BUSY, S_DONE (2 bits).
- One natural sub-module: load_extend, the combinational load extraction (inputs rbuf, off, load_sel; output 32-bit data).

Test Plan:
- LB, alu_res=0x1003, dmem_rdata=0x80112233, ack 1 cycle after req -> dmem_addr=0x1000, dmem_be=4'hF, dmem_we=0, mem_stall high for 2 edges, memwb_data=0xFFFFFF80.
- LHU, alu_res=0x22, rdata=0xBEEF1234 -> memwb_data=0x0000BEEF. Same setup with LH -> memwb_data=0xFFFFBEEF.
- SB, mem_byte_w_en_out=4'b0100, aligned_rt_data=0x00AB0000 -> dmem_we=1, dmem_be=4'b0100, dmem_wdata=0x00AB0000. memwb_data=alu_res.
- Store with mem_byte_w_en_out=0, or mem_nop=1 -> no dmem_req and mem_stall=0.
- No ack for TIMEOUT=64 edges -> dmem_req drops on edge 64, memwb_bus_err=1, memwb_data=0, pipeline resumes.
- Cases on the MEM/WB register and FSM:
  - Flush asserted while BUSY -> ignored; data is written once ack arrives.
  - Reset while BUSY -> dmem_req=0 and memwb_nop=1 at the next negedge.
  - cu_stall held by another source in DONE -> memwb holds, and the access is not reissued.
